// File: rtl/mem_write_checker.sv
//==============================================================================
// Module      : mem_write_checker
// Description : Self-check monitor for the CPU data-memory write port.
//               After reset release it classifies every store as scratch,
//               pass or illegal. It also enforces a cycle timeout and a
//               minimum scratch-write count, and it latches sticky pass/fail
//               status together with diagnostics.
//
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               memwrite   - data-memory write strobe
//               dataadr    - store address   [ADDR_W]
//               writedata  - store data      [DATA_W]
//               done       - test finished (sticky)
//               pass       - test passed (sticky)
//               fail_code  - 000 none/pass, 001 illegal addr, 010 bad data,
//                            011 timeout, 100 too few scratch writes
//               wr_count   - scratch stores accepted      [CNT_W]
//               cyc_count  - cycles spent running         [CNT_W]
//               fail_addr  - offending store address      [ADDR_W]
//               fail_data  - offending store data         [DATA_W]
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_write_checker #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PASS_ADDR  = 84,
    parameter int unsigned PASS_DATA  = 7,
    parameter int unsigned SCR_BASE   = 80,
    parameter int unsigned SCR_LIMIT  = 80,
    parameter int unsigned MIN_WRITES = 0,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_code,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  cyc_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam logic [ADDR_W-1:0] c_pass_addr = ADDR_W'(PASS_ADDR);
    localparam logic [DATA_W-1:0] c_pass_data = DATA_W'(PASS_DATA);
    localparam logic [ADDR_W-1:0] c_scr_base  = ADDR_W'(SCR_BASE);
    localparam logic [ADDR_W-1:0] c_scr_limit = ADDR_W'(SCR_LIMIT);
    localparam logic [CNT_W-1:0]  c_min_wr    = CNT_W'(MIN_WRITES);
    // Last cycle index allowed before timing out; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0]  c_to_last   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit                c_to_en     = (TIMEOUT != 0);

    localparam logic [2:0] c_code_none    = 3'b000;
    localparam logic [2:0] c_code_illegal = 3'b001;
    localparam logic [2:0] c_code_data    = 3'b010;
    localparam logic [2:0] c_code_timeout = 3'b011;
    localparam logic [2:0] c_code_few     = 3'b100;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic                r_done,      w_done_nxt;
    logic                r_pass,      w_pass_nxt;
    logic [2:0]          r_fail_code, w_fail_code_nxt;
    logic [CNT_W-1:0]    r_wr_count,  w_wr_count_nxt;
    logic [CNT_W-1:0]    r_cyc_count, w_cyc_count_nxt;
    logic [ADDR_W-1:0]   r_fail_addr, w_fail_addr_nxt;
    logic [DATA_W-1:0]   r_fail_data, w_fail_data_nxt;

    logic                w_at_pass;
    logic                w_in_scr;
    logic                w_term_store;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= c_code_none;
            r_wr_count  <= '0;
            r_cyc_count <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_code <= w_fail_code_nxt;
            r_wr_count  <= w_wr_count_nxt;
            r_cyc_count <= w_cyc_count_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_code_nxt = r_fail_code;
        w_wr_count_nxt  = r_wr_count;
        w_cyc_count_nxt = r_cyc_count;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;
        w_term_store    = 1'b0;

        // The pass-address test is evaluated first, so a PASS_ADDR placed
        // inside the scratch window is never counted as a scratch store.
        w_at_pass = (dataadr == c_pass_addr);
        w_in_scr  = (dataadr >= c_scr_base) && (dataadr <= c_scr_limit);

        if (r_state == S_RUN) begin
            if (memwrite) begin
                if (w_at_pass) begin
                    w_term_store = 1'b1;
                    w_done_nxt   = 1'b1;
                    if (writedata != c_pass_data) begin
                        w_state_nxt     = S_FAIL;
                        w_fail_code_nxt = c_code_data;
                        w_fail_addr_nxt = dataadr;
                        w_fail_data_nxt = writedata;
                    end else if (r_wr_count < c_min_wr) begin
                        w_state_nxt     = S_FAIL;
                        w_fail_code_nxt = c_code_few;
                        w_fail_addr_nxt = dataadr;
                        w_fail_data_nxt = writedata;
                    end else begin
                        w_state_nxt = S_PASS;
                        w_pass_nxt  = 1'b1;
                    end
                end else if (w_in_scr) begin
                    if (r_wr_count != '1) begin
                        w_wr_count_nxt = r_wr_count + 1'b1;
                    end
                end else begin
                    w_term_store    = 1'b1;
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = S_FAIL;
                    w_fail_code_nxt = c_code_illegal;
                    w_fail_addr_nxt = dataadr;
                    w_fail_data_nxt = writedata;
                end
            end

            // A terminating store on the same edge overrides the timeout.
            if (c_to_en && !w_term_store && (r_cyc_count == c_to_last)) begin
                w_done_nxt      = 1'b1;
                w_state_nxt     = S_FAIL;
                w_fail_code_nxt = c_code_timeout;
                w_fail_addr_nxt = '0;
                w_fail_data_nxt = '0;
            end

            // The counter stops on the deciding edge so it reports the last
            // cycle actually spent running.
            if ((w_state_nxt == S_RUN) && (r_cyc_count != '1)) begin
                w_cyc_count_nxt = r_cyc_count + 1'b1;
            end
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fail_code;
    assign wr_count  = r_wr_count;
    assign cyc_count = r_cyc_count;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
//==============================================================================
// Module      : tb_mem_write_checker
// Description : Directed self-checking bench for mem_write_checker. Three
//               instances cover the default build, a short timeout build and
//               a minimum-write build with a wider scratch window.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_write_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // a: defaults, b: TIMEOUT=20, c: MIN_WRITES=3 with scratch window 64..80
    logic        rst_a, rst_b, rst_c;
    logic        mw_a,  mw_b,  mw_c;
    logic [31:0] adr_a, adr_b, adr_c;
    logic [31:0] wd_a,  wd_b,  wd_c;

    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;
    logic [2:0]  code_a, code_b, code_c;
    logic [15:0] wr_a,   wr_b,   wr_c;
    logic [15:0] cyc_a,  cyc_b,  cyc_c;
    logic [31:0] fa_a,   fa_b,   fa_c;
    logic [31:0] fd_a,   fd_b,   fd_c;

    mem_write_checker u_a (
        .clk(clk), .rst(rst_a), .memwrite(mw_a), .dataadr(adr_a), .writedata(wd_a),
        .done(done_a), .pass(pass_a), .fail_code(code_a), .wr_count(wr_a),
        .cyc_count(cyc_a), .fail_addr(fa_a), .fail_data(fd_a)
    );

    mem_write_checker #(.TIMEOUT(20)) u_b (
        .clk(clk), .rst(rst_b), .memwrite(mw_b), .dataadr(adr_b), .writedata(wd_b),
        .done(done_b), .pass(pass_b), .fail_code(code_b), .wr_count(wr_b),
        .cyc_count(cyc_b), .fail_addr(fa_b), .fail_data(fd_b)
    );

    mem_write_checker #(.MIN_WRITES(3), .SCR_BASE(64), .SCR_LIMIT(80)) u_c (
        .clk(clk), .rst(rst_c), .memwrite(mw_c), .dataadr(adr_c), .writedata(wd_c),
        .done(done_c), .pass(pass_c), .fail_code(code_c), .wr_count(wr_c),
        .cyc_count(cyc_c), .fail_addr(fa_c), .fail_data(fd_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input int sel, input logic [31:0] a, input logic [31:0] d);
        case (sel)
            0:       begin mw_a = 1'b1; adr_a = a; wd_a = d; end
            1:       begin mw_b = 1'b1; adr_b = a; wd_b = d; end
            default: begin mw_c = 1'b1; adr_c = a; wd_c = d; end
        endcase
        @(posedge clk);
        #1;
        mw_a = 1'b0; mw_b = 1'b0; mw_c = 1'b0;
    endtask

    task automatic pulse_rst(input int sel);
        case (sel)
            0:       rst_a = 1'b1;
            1:       rst_b = 1'b1;
            default: rst_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        mw_a = 1'b0;  mw_b = 1'b0;  mw_c = 1'b0;
        adr_a = '0; adr_b = '0; adr_c = '0;
        wd_a  = '0; wd_b  = '0; wd_c  = '0;

        // Plan 1: ten reset cycles, then two scratch stores and the pass store
        idle(10);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_pass",  32'(pass_a), 32'd0);
        check("rst_code",  32'(code_a), 32'd0);
        check("rst_wr",    32'(wr_a),   32'd0);
        check("rst_cyc",   32'(cyc_a),  32'd0);
        check("rst_faddr", fa_a,        32'd0);
        check("rst_fdata", fd_a,        32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Pass address on the bus without the strobe must be ignored
        adr_a = 32'd84; wd_a = 32'd6;
        idle(1);
        check("nomw_done", 32'(done_a), 32'd0);
        check("nomw_cyc",  32'(cyc_a),  32'd1);

        store(0, 32'd80, 32'd5);
        check("scr1_wr",   32'(wr_a),   32'd1);
        check("scr1_done", 32'(done_a), 32'd0);
        store(0, 32'd80, 32'd9);
        check("scr2_wr",   32'(wr_a),   32'd2);
        store(0, 32'd84, 32'd7);
        check("p1_done",   32'(done_a), 32'd1);
        check("p1_pass",   32'(pass_a), 32'd1);
        check("p1_code",   32'(code_a), 32'd0);
        check("p1_wr",     32'(wr_a),   32'd2);

        // Activity after PASS is ignored
        store(0, 32'd88, 32'd1);
        check("post_pass", 32'(pass_a), 32'd1);
        check("post_code", 32'(code_a), 32'd0);
        check("post_fa",   fa_a,        32'd0);

        // Plan 6: reset from PASS clears everything, then an illegal store
        pulse_rst(0);
        check("rr_done", 32'(done_a), 32'd0);
        check("rr_pass", 32'(pass_a), 32'd0);
        check("rr_wr",   32'(wr_a),   32'd0);
        check("rr_cyc",  32'(cyc_a),  32'd0);
        store(0, 32'd100, 32'd0);
        check("ill100_code", 32'(code_a), 32'd1);
        check("ill100_fa",   fa_a,        32'd100);
        check("ill100_done", 32'(done_a), 32'd1);
        check("ill100_pass", 32'(pass_a), 32'd0);

        // Plan 2: wrong data at the pass address
        pulse_rst(0);
        store(0, 32'd84, 32'd6);
        check("bad_done", 32'(done_a), 32'd1);
        check("bad_pass", 32'(pass_a), 32'd0);
        check("bad_code", 32'(code_a), 32'd2);
        check("bad_fa",   fa_a,        32'd84);
        check("bad_fd",   fd_a,        32'd6);

        // Plan 3: illegal address, then a pass store that must not count
        pulse_rst(0);
        store(0, 32'd88, 32'd7);
        check("ill_code", 32'(code_a), 32'd1);
        check("ill_fa",   fa_a,        32'd88);
        check("ill_fd",   fd_a,        32'd7);
        store(0, 32'd84, 32'd7);
        check("ill_nopass", 32'(pass_a), 32'd0);
        check("ill_sticky", 32'(code_a), 32'd1);
        check("ill_fa2",    fa_a,        32'd88);

        // Plan 4: timeout fires on the 20th edge after reset release
        pulse_rst(1);
        idle(19);
        check("to_early_done", 32'(done_b), 32'd0);
        check("to_early_cyc",  32'(cyc_b),  32'd19);
        idle(1);
        check("to_done", 32'(done_b), 32'd1);
        check("to_pass", 32'(pass_b), 32'd0);
        check("to_code", 32'(code_b), 32'd3);
        check("to_cyc",  32'(cyc_b),  32'd19);
        check("to_fa",   fa_b,        32'd0);
        check("to_fd",   fd_b,        32'd0);
        idle(3);
        check("to_cyc_frozen", 32'(cyc_b), 32'd19);

        // Pass store on the timeout edge wins
        pulse_rst(1);
        idle(19);
        store(1, 32'd84, 32'd7);
        check("tow_pass", 32'(pass_b), 32'd1);
        check("tow_done", 32'(done_b), 32'd1);
        check("tow_code", 32'(code_b), 32'd0);

        // Plan 5: minimum scratch-write count
        pulse_rst(2);
        store(2, 32'd64, 32'd1);
        store(2, 32'd72, 32'd2);
        store(2, 32'd84, 32'd7);
        check("few_code", 32'(code_c), 32'd4);
        check("few_pass", 32'(pass_c), 32'd0);
        check("few_fa",   fa_c,        32'd84);
        check("few_fd",   fd_c,        32'd7);
        check("few_wr",   32'(wr_c),   32'd2);

        pulse_rst(2);
        store(2, 32'd64, 32'd1);
        store(2, 32'd72, 32'd2);
        store(2, 32'd80, 32'd3);
        store(2, 32'd84, 32'd7);
        check("min_pass", 32'(pass_c), 32'd1);
        check("min_code", 32'(code_c), 32'd0);
        check("min_wr",   32'(wr_c),   32'd3);

        // Scratch window edges: just above the limit and just below the base
        pulse_rst(2);
        store(2, 32'd81, 32'd0);
        check("above_code", 32'(code_c), 32'd1);
        check("above_fa",   fa_c,        32'd81);
        pulse_rst(2);
        store(2, 32'd63, 32'd5);
        check("below_code", 32'(code_c), 32'd1);
        check("below_fd",   fd_c,        32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised self-check monitor for the CPU top-level data-memory write port; next generation of the bench-only memwrite pass/fail check.
- Watches every data-memory store after reset release and classifies it as scratch, pass or illegal.
- Enforces a cycle timeout and a minimum scratch-write count; latches sticky pass/fail status plus diagnostics.
- Instantiated beside `top` in simulation and on-board (status to LEDs), so it must be fully synchronous with no delays or system tasks.

Parameters:
- ADDR_W, 32, width of dataadr.
- DATA_W, 32, width of writedata.
- PASS_ADDR, 84, store address that terminates the test.
- PASS_DATA, 7, data required at PASS_ADDR for success.
- SCR_BASE, 80, lowest legal scratch store address (inclusive).
- SCR_LIMIT, 80, highest legal scratch store address (inclusive).
- MIN_WRITES, 0, scratch stores required before the pass store.
- TIMEOUT, 1000, run cycles allowed before timeout; 0 disables the timeout.
- CNT_W, 16, width of the cycle and write counters.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- memwrite, input, 1, data-memory write strobe from the CPU.
- dataadr, input, ADDR_W, store address.
- writedata, input, DATA_W, store data.
- done, output, 1, test finished (pass or fail); sticky.
- pass, output, 1, test passed; sticky.
- fail_code, output, 3, 000 none/pass; 001 illegal address; 010 wrong data at PASS_ADDR; 011 timeout; 100 too few scratch writes.
- wr_count, output, CNT_W, scratch stores accepted.
- cyc_count, output, CNT_W, cycles spent in RUN.
- fail_addr, output, ADDR_W, address of the offending store (0 for timeout).
- fail_data, output, DATA_W, data of the offending store (0 for timeout).

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset state: while rst=1 at a rising edge, go to RUN and clear every output to 0.
- States: RUN, PASS, FAIL. PASS and FAIL are terminal and are left only via rst.
- In RUN, cyc_count increments every cycle, saturating at all-ones.
- In RUN with memwrite=1, classify the store, in priority order:
  - dataadr==PASS_ADDR and writedata!=PASS_DATA: FAIL, code 010.
  - dataadr==PASS_ADDR, writedata==PASS_DATA, wr_count<MIN_WRITES: FAIL, code 100.
  - dataadr==PASS_ADDR, writedata==PASS_DATA, wr_count>=MIN_WRITES: PASS.
  - SCR_BASE<=dataadr<=SCR_LIMIT (unsigned): wr_count+1, saturating; stay in RUN.
  - Any other address: FAIL, code 001.
- Timeout: in RUN, TIMEOUT!=0, cyc_count==TIMEOUT-1 and no terminating store this cycle: FAIL, code 011, fail_addr/fail_data=0.
- Same-edge store and timeout: the store classification wins.
- On entering FAIL from a store, capture dataadr and writedata into fail_addr/fail_data in the same edge.
- Output timing: done, pass, fail_code and fail_* are registered and valid the cycle after the deciding edge (one-cycle latency).
- Terminal states: all counters freeze; later memwrite activity is ignored; pass and fail_code never change.
- PASS_ADDR inside the scratch range: pass-address rules take precedence.
- Mid-run reset: rst asserted mid-run or after done clears all state in one edge and restarts RUN on the next cycle.
- memwrite=0: dataadr/writedata are don't-care and never alter state.

Test Plan:
1. Defaults; rst for 10 cycles, then stores (80,5), (80,9), (84,7) -> wr_count=2, pass=1, done=1, fail_code=000 one cycle after the (84,7) edge.
2. Defaults; store (84,6) -> done=1, pass=0, fail_code=010, fail_addr=84, fail_data=6.
3. Defaults; store (88,7) -> fail_code=001, fail_addr=88; a following (84,7) does not set pass.
4. TIMEOUT=20, no stores -> fail_code=011 exactly 20 cycles after reset release, cyc_count frozen at 19. Repeat with (84,7) on cycle 19 -> pass=1.
5. MIN_WRITES=3, SCR_BASE=64, SCR_LIMIT=80; stores (64,1), (72,2), (84,7) -> fail_code=100. Then stores (64,1), (72,2), (80,3), (84,7) -> pass=1, wr_count=3.
6. Reach PASS, assert rst for 1 cycle -> all outputs 0; then store (100,0) -> fail_code=001, fail_addr=100.
